// File: rtl/tick_event_pkg.sv
// rtl/tick_event_pkg.sv - shared types and defaults for the tick event counter
package tick_event_pkg;

   localparam int STATE_W             = 2;
   localparam int DEF_WIDTH           = 16;
   localparam int DEF_SYNC_STAGES     = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/sync_rise_detect.sv
// rtl/sync_rise_detect.sv - synchronizes slow_in and emits a registered one-cycle tick per rising edge
module sync_rise_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_in,
   input  logic rst,
   input  logic slow_in,
   output logic tick
);

   localparam logic [2:0] SUP_LAST = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic [2:0]             sup_cnt;
   logic                   armed;

   // Ticks stay masked until the chain and history flop hold real samples,
   // so a level already high at reset release never looks like an edge.
   assign armed = (sup_cnt == SUP_LAST);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         sup_cnt <= 3'd0;
         tick    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
         hist_q <= sync_q[SYNC_STAGES-1];
         if (!armed)
            sup_cnt <= sup_cnt + 3'd1;
         tick <= armed & sync_q[SYNC_STAGES-1] & ~hist_q;
      end
   end

endmodule

// File: rtl/tick_event_counter.sv
// rtl/tick_event_counter.sv - counts qualified slow_in rising edges up to a latched target
module tick_event_counter
   import tick_event_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             slow_in,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic [WIDTH-1:0] target,
   output logic             tick,
   output logic [WIDTH-1:0] count,
   output logic             match,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] count_inc;

   sync_rise_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_rise (
      .clk_in  (clk_in),
      .rst     (rst),
      .slow_in (slow_in),
      .tick    (tick)
   );

   assign count_inc = count + WIDTH'(1);
   assign busy      = (state == ST_RUN);
   assign done      = (state == ST_DONE);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         count <= '0;
         tgt_q <= '0;
         match <= 1'b0;
      end else begin
         match <= 1'b0;
         if (clear) begin
            state <= ST_IDLE;
            count <= '0;
         end else if (start) begin
            // Start wins over stop and over a coincident tick in every state.
            tgt_q <= target;
            count <= '0;
            if (target == '0) begin
               state <= ST_DONE;
               match <= 1'b1;
            end else begin
               state <= ST_RUN;
            end
         end else begin
            case (state)
               ST_RUN: begin
                  if (stop) begin
                     state <= ST_IDLE;
                  end else if (tick) begin
                     count <= count_inc;
                     if (count_inc == tgt_q) begin
                        state <= ST_DONE;
                        match <= 1'b1;
                     end
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tick_event_counter.sv
// tb/tb_tick_event_counter.sv - directed self-checking bench for tick_event_counter
module tb_tick_event_counter;

   logic        clk_in;
   logic        rst;
   logic        slow_in;
   logic        start;
   logic        stop;
   logic        clear;
   logic [15:0] target;
   logic        tick;
   logic [15:0] count;
   logic        match;
   logic        busy;
   logic        done;

   logic        start4;
   logic [3:0]  target4;
   logic        tick4;
   logic [3:0]  count4;
   logic        match4;
   logic        busy4;
   logic        done4;

   int n_checks = 0;
   int n_fail   = 0;
   int m4_hits  = 0;

   tick_event_counter dut (
      .clk_in  (clk_in),
      .rst     (rst),
      .slow_in (slow_in),
      .start   (start),
      .stop    (stop),
      .clear   (clear),
      .target  (target),
      .tick    (tick),
      .count   (count),
      .match   (match),
      .busy    (busy),
      .done    (done)
   );

   tick_event_counter #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
      .clk_in  (clk_in),
      .rst     (rst),
      .slow_in (slow_in),
      .start   (start4),
      .stop    (stop),
      .clear   (clear),
      .target  (target4),
      .tick    (tick4),
      .count   (count4),
      .match   (match4),
      .busy    (busy4),
      .done    (done4)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk_in);
      #1;
      if (match4) m4_hits++;
   endtask

   // One slow_in high/low period; tick appears after the 3rd sampling edge.
   task automatic slow_pulse(input string tag, input logic [15:0] exp_count, input logic exp_match);
      slow_in = 1'b1;
      cyc();
      cyc();
      check({tag, "_tick_early"}, 32'(tick), 32'd0);
      cyc();
      check({tag, "_tick"}, 32'(tick), 32'd1);
      cyc();
      check({tag, "_tick_width"}, 32'(tick), 32'd0);
      check({tag, "_count"}, 32'(count), 32'(exp_count));
      check({tag, "_match"}, 32'(match), 32'(exp_match));
      slow_in = 1'b0;
      cyc();
      check({tag, "_match_after"}, 32'(match), 32'd0);
      repeat (3) cyc();
   endtask

   task automatic slow_edge;
      slow_in = 1'b1;
      repeat (4) cyc();
      slow_in = 1'b0;
      repeat (4) cyc();
   endtask

   initial begin
      int n_ticks;
      int first_idx;
      int second_idx;
      int bad;

      rst = 1'b1; slow_in = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
      target = 16'd0; start4 = 1'b0; target4 = 4'd0;
      repeat (3) cyc();
      check("rst_count", 32'(count), 32'd0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_flags", {29'd0, match, busy, done}, 32'd0);

      // slow_in high through reset release, then period-60 square wave.
      rst = 1'b0;
      n_ticks = 0; first_idx = -1; second_idx = -1;
      for (int c = 0; c < 150; c++) begin
         slow_in = (c < 30) ? 1'b1 : (((c / 30) % 2) == 0);
         cyc();
         if (tick) begin
            n_ticks++;
            if (first_idx < 0) first_idx = c;
            else if (second_idx < 0) second_idx = c;
         end
      end
      check("release_first_tick", 32'(first_idx), 32'd62);
      check("release_tick_cycles", 32'(n_ticks), 32'd2);
      check("release_spacing", 32'(second_idx - first_idx), 32'd60);
      slow_in = 1'b0;
      repeat (4) cyc();

      // target=3, target changes after start must be ignored.
      target = 16'd3; start = 1'b1;
      cyc();
      start = 1'b0; target = 16'd1;
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_count0", 32'(count), 32'd0);
      slow_pulse("t3_e1", 16'd1, 1'b0);
      slow_pulse("t3_e2", 16'd2, 1'b0);
      slow_pulse("t3_e3", 16'd3, 1'b1);
      check("t3_done", 32'(done), 32'd1);
      check("t3_busy_off", 32'(busy), 32'd0);
      slow_pulse("t3_e4", 16'd3, 1'b0);

      // target=0 finishes immediately.
      target = 16'd0; start = 1'b1;
      cyc();
      start = 1'b0;
      check("t0_done", 32'(done), 32'd1);
      check("t0_match", 32'(match), 32'd1);
      check("t0_count", 32'(count), 32'd0);
      check("t0_busy", 32'(busy), 32'd0);
      cyc();
      check("t0_match_off", 32'(match), 32'd0);

      // target=5, stop coincident with the 3rd tick.
      target = 16'd5; start = 1'b1;
      cyc();
      start = 1'b0;
      slow_pulse("t5_e1", 16'd1, 1'b0);
      slow_pulse("t5_e2", 16'd2, 1'b0);
      slow_in = 1'b1;
      repeat (3) cyc();
      check("stop_tick", 32'(tick), 32'd1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_count", 32'(count), 32'd2);
      slow_in = 1'b0;
      repeat (4) cyc();
      check("stop_hold", 32'(count), 32'd2);
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("restart_count", 32'(count), 32'd0);
      check("restart_busy", 32'(busy), 32'd1);

      // clear and start together at count=4.
      slow_pulse("cl_e1", 16'd1, 1'b0);
      slow_pulse("cl_e2", 16'd2, 1'b0);
      slow_pulse("cl_e3", 16'd3, 1'b0);
      slow_pulse("cl_e4", 16'd4, 1'b0);
      clear = 1'b1; start = 1'b1;
      cyc();
      clear = 1'b0; start = 1'b0;
      check("clear_state", {30'd0, busy, done}, 32'd0);
      check("clear_count", 32'(count), 32'd0);
      check("clear_match", 32'(match), 32'd0);

      // WIDTH=4 instance reaches 15 without wrapping.
      target4 = 4'd15; start4 = 1'b1;
      cyc();
      start4 = 1'b0;
      m4_hits = 0;
      for (int i = 0; i < 15; i++) slow_edge();
      check("w4_count", 32'(count4), 32'd15);
      check("w4_match_pulses", 32'(m4_hits), 32'd1);
      check("w4_done", 32'(done4), 32'd1);
      slow_edge();
      check("w4_no_wrap", 32'(count4), 32'd15);

      // Asynchronous reset mid-run.
      start4 = 1'b1;
      cyc();
      start4 = 1'b0;
      slow_edge();
      slow_edge();
      check("w4_pre_rst", 32'(count4), 32'd2);
      #2 rst = 1'b1;
      #1;
      check("rst_async_count4", 32'(count4), 32'd0);
      check("rst_async_flags4", {29'd0, match4, busy4, done4}, 32'd0);
      check("rst_async_tick", {30'd0, tick, tick4}, 32'd0);
      cyc();
      rst = 1'b0;
      bad = 0;
      m4_hits = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (tick || tick4 || match || busy4) bad++;
      end
      check("rst_release_quiet", 32'(bad + m4_hits), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
